csr_timer: RTL
==============

# csr_timer

Machine timer peripheral on the CSR bus: a prescaled 64-bit `mtime` counter and a 64-bit `mtimecmp` compare register, readable and writable through the core's CSR interface. It drives the `irq_timer` input of `Pipeline`, which top-level wrappers currently tie to 0. Its `rdata`/`valid` outputs are OR-combined with the other CSR peripherals, such as the UART, counter and LED blocks.

## Interface
- `BASE_ADDR`, 12'hbc4: CSR address of register 0; the block occupies `BASE_ADDR`..`BASE_ADDR+4`.
- `DIVIDE`, 200: clock cycles per `mtime` tick, range 1..65535. At 200 MHz the default gives a 1 MHz tick.
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `read`, in, 1: CSR read strobe.
- `modify`, in, 3: CSR write operation. `modify[1:0]`: 00 none, 01 write, 10 set bits, 11 clear bits. `modify[2]` is ignored.
- `wdata`, in, 32: CSR write operand.
- `addr`, in, 12: CSR address.
- `rdata`, out, 32: read data; 0 when the block is not selected.
- `valid`, out, 1: address hits `BASE_ADDR`..`BASE_ADDR+4` and `read` or `modify[1:0]`≠0.
- `irq_timer`, out, 1: timer interrupt request, level.

## Operation
- Register map, as offsets from `BASE_ADDR`:
  - +0: `mtime[31:0]`
  - +1: `mtime[63:32]`
  - +2: `mtimecmp[31:0]`
  - +3: `mtimecmp[63:32]`
  - +4: `ctrl`. Bit 0 `EN` is read/write. Bit 1 `PEND` is read-only and mirrors `irq_timer`. Other bits read 0 and ignore writes.
- Write value is computed from the current register value `old`:
  - write: `wdata`
  - set: `old | wdata`
  - clear: `old & ~wdata`
- Prescaler:
  - 16-bit `presc` counts 0..`DIVIDE-1` while `EN`=1, then wraps to 0.
  - `tick` is asserted in the cycle where `presc`==`DIVIDE-1`.
  - While `EN`=0, `presc` holds its value and no tick occurs.
  - With `DIVIDE`=1, every enabled cycle is a tick.
- `mtime` increments by 1 on each tick, with a full 64-bit carry from low half into high half. It wraps from 2^64−1 to 0.
- Simultaneous CSR write and tick on the same `mtime` half: the written value is stored and the increment is discarded for that half.
  - A tick that carries into the half not being written still applies to that half.
  - Example: writing lo while lo=FFFFFFFF ticks stores `wdata` in lo and still increments hi.
- Writing `ctrl.EN` from 1 to 0 resets `presc` to 0.
- Compare:
  - `hit` = (`mtime` ≥ `mtimecmp`), unsigned 64-bit.
  - `irq_timer` is the registered value of `hit`, evaluated from post-update register values.
  - `irq_timer` is independent of `EN`: a stopped timer that already satisfies the compare keeps the request asserted.
- The request is cleared only by raising `mtimecmp` above `mtime` or by lowering `mtime`.
  - Software writes `mtimecmp` hi first, with all ones, to avoid a spurious request during a two-half update.
- Out-of-range addresses:
  - `valid`=0 and `rdata`=0.
  - Writes have no effect.
- Reset values:
  - `mtime`=0, `mtimecmp`=FFFF_FFFF_FFFF_FFFF, `EN`=0, `presc`=0, `irq_timer`=0.
  - Outputs `rdata`=0 and `valid`=0 whenever `read` and `modify` are inactive.
- Reset asserted mid-operation: all state returns to reset values immediately, with no clock required. `irq_timer` drops asynchronously.

## Timing
- `rdata` and `valid` are combinational from `addr`, `read` and `modify`, with zero latency.
  - Read data is the register value before any write in the same cycle, i.e. read-old for CSRRW/CSRRS/CSRRC.
- Writes take effect at the rising `clk` edge of the strobe cycle and are visible on reads from the next cycle.
- `irq_timer` latency:
  - Asserts at the edge following the first cycle in which the registered `mtime`/`mtimecmp` satisfy `hit`. That is 1 clock after the tick or write that caused it.
  - Deasserts with the same 1-clock latency.
- `mtime` first increments `DIVIDE` clocks after `EN` is written to 1, counting from the write edge.

## Test plan
- Reset check: assert `rst` asynchronously mid-cycle with `mtime`=5 and `irq_timer`=1.
  - `irq_timer` drops without a clock edge.
  - After release: reads of +0..+4 return 0, 0, FFFFFFFF, FFFFFFFF, 0.
- Prescale: `DIVIDE`=4, write `ctrl`=1, wait 40 clocks.
  - Read +0 returns 10.
  - Write `ctrl`=0, wait 20 clocks: +0 still returns 10.
- Carry and wraparound:
  - Write lo=FFFFFFFE, hi=0, enable with `DIVIDE`=1. After 2 ticks: hi=1, lo=0.
  - Preload lo=hi=FFFFFFFF, 1 tick: both read 0.
- Interrupt:
  - Write cmp hi=0, cmp lo=100, `DIVIDE`=1, enable.
  - `irq_timer` rises exactly 1 clock after `mtime` reaches 100, and `ctrl` reads 3.
  - Write cmp lo=200: `irq_timer` falls 1 clock later.
- Set/clear and read-old:
  - On `ctrl`=0, a set op with `wdata`=1 returns 0 in `rdata` and leaves `EN`=1.
  - A clear op with `wdata`=1 returns 1 (or 3 if `PEND`=1) and leaves `EN`=0.
  - Writing `wdata`=2 to `ctrl` leaves `PEND` unchanged.
- Write/tick collision:
  - `DIVIDE`=1, lo=FFFFFFFF, hi=7, write lo=0x55 in a tick cycle.
  - Next cycle: lo=0x55 and hi=8.
  - Access to `BASE_ADDR`+5 returns `valid`=0.

Source files
------------

// File: rtl/csr_timer.sv
// Machine timer on the CSR bus: a prescaled 64-bit mtime, a 64-bit mtimecmp and a level
// interrupt that is asserted while mtime >= mtimecmp.
module csr_timer #(
  parameter logic [11:0] BASE_ADDR = 12'hbc4,
  parameter int          DIVIDE    = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read,
  input  logic [2:0]  modify,
  input  logic [31:0] wdata,
  input  logic [11:0] addr,
  output logic [31:0] rdata,
  output logic        valid,
  output logic        irq_timer
);

  localparam logic [15:0] PRESC_MAX = 16'(DIVIDE - 1);

  logic [63:0] mtime_q, mtime_d, mtime_inc;
  logic [63:0] cmp_q, cmp_d;
  logic [15:0] presc_q, presc_d;
  logic        en_q, en_d;
  logic        irq_q;
  logic        tick;

  logic [11:0] off;
  logic        sel, wr;
  logic [31:0] old, wval;
  logic        unused_mod;

  assign unused_mod = modify[2];

  // Out-of-window addresses below BASE_ADDR wrap to large offsets and miss.
  assign off   = addr - BASE_ADDR;
  assign sel   = (off <= 12'd4);
  assign wr    = sel && (modify[1:0] != 2'b00);
  assign valid = sel && (read || (modify[1:0] != 2'b00));

  always_comb begin
    old = '0;
    case (off[2:0])
      3'd0:    old = mtime_q[31:0];
      3'd1:    old = mtime_q[63:32];
      3'd2:    old = cmp_q[31:0];
      3'd3:    old = cmp_q[63:32];
      3'd4:    old = {30'b0, irq_q, en_q};
      default: old = '0;
    endcase
  end

  always_comb begin
    wval = old;
    case (modify[1:0])
      2'b01:   wval = wdata;
      2'b10:   wval = old | wdata;
      2'b11:   wval = old & ~wdata;
      default: wval = old;
    endcase
  end

  // Read-old: rdata reflects registers before any same-cycle write.
  assign rdata = valid ? old : 32'h0;

  assign tick      = en_q && (presc_q == PRESC_MAX);
  assign mtime_inc = mtime_q + 64'd1;

  always_comb begin
    mtime_d = tick ? mtime_inc : mtime_q;
    cmp_d   = cmp_q;
    en_d    = en_q;
    presc_d = presc_q;

    if (tick)      presc_d = 16'd0;
    else if (en_q) presc_d = presc_q + 16'd1;

    // A written half takes the CSR value; the other half keeps any tick carry.
    if (wr) begin
      case (off[2:0])
        3'd0: mtime_d[31:0]  = wval;
        3'd1: mtime_d[63:32] = wval;
        3'd2: cmp_d[31:0]    = wval;
        3'd3: cmp_d[63:32]   = wval;
        3'd4: begin
          en_d = wval[0];
          if (en_q && !wval[0]) presc_d = 16'd0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime_q <= '0;
      cmp_q   <= '1;
      en_q    <= 1'b0;
      presc_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      mtime_q <= mtime_d;
      cmp_q   <= cmp_d;
      en_q    <= en_d;
      presc_q <= presc_d;
      irq_q   <= (mtime_q >= cmp_q);
    end
  end

  assign irq_timer = irq_q;

endmodule
